// File: rtl/cell_test_sequencer.sv
// Sequences every input vector into one selected standard cell, samples its Y output and scores it against a built-in truth table.
// Optional macro CELL_TEST_CAPTURE_EN adds obs_o, which holds the raw Y sample taken for each vector.
module cell_test_sequencer #(
  parameter int NCELLS = 19,
  parameter int SETTLE = 2,
  parameter int CNTW   = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [4:0]        cell_sel_i,
  input  logic [NCELLS-1:0] cell_y_i,
  output logic [3:0]        cell_in_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [4:0]        err_cnt_o,
  output logic [15:0]       fail_mask_o
`ifdef CELL_TEST_CAPTURE_EN
  ,
  output logic [15:0]       obs_o
`endif
);

  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

  state_t          state_q;
  logic [4:0]      sel_q;
  logic [3:0]      vec_q;
  logic [CNTW-1:0] cnt_q;
  logic            busy_q, done_q, pass_q;
  logic [4:0]      err_q, err_d;
  logic [15:0]     mask_q, mask_d;
  logic            y_smp, miss, last;
`ifdef CELL_TEST_CAPTURE_EN
  logic [15:0]     obs_q, obs_d;
`endif

  // Vector count is 2^(number of cell inputs).
  function automatic logic [4:0] vec_count(input logic [4:0] sel);
    case (sel)
      5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9:           vec_count = 5'd2;
      5'd0, 5'd1, 5'd11, 5'd13, 5'd16, 5'd17, 5'd18: vec_count = 5'd4;
      5'd2, 5'd10, 5'd12, 5'd14:                     vec_count = 5'd8;
      default:                                       vec_count = 5'd16;
    endcase
  endfunction

  function automatic logic expected_y(input logic [4:0] sel, input logic [3:0] v);
    logic a, b, c, d;
    {d, c, b, a} = v;
    case (sel)
      5'd0, 5'd1:                         expected_y = a & b;
      5'd2:                               expected_y = !((a & b) | c);
      5'd3:                               expected_y = !((a & b) | (c & d));
      5'd4:                               expected_y = a;
      5'd5, 5'd6, 5'd7, 5'd8, 5'd9:       expected_y = !a;
      5'd10:                              expected_y = c ? b : a;
      5'd11:                              expected_y = !(a & b);
      5'd12:                              expected_y = !(a & b & c);
      5'd13:                              expected_y = !(a | b);
      5'd14:                              expected_y = !((a | b) & c);
      5'd15:                              expected_y = !((a | b) & (c | d));
      5'd16, 5'd17:                       expected_y = a | b;
      default:                            expected_y = a ^ b;
    endcase
  endfunction

  always_comb begin
    y_smp          = cell_y_i[sel_q];
    miss           = (y_smp != expected_y(sel_q, vec_q));
    last           = ((5'(vec_q) + 5'd1) == vec_count(sel_q));
    err_d          = err_q + 5'(miss);
    mask_d         = mask_q;
    mask_d[vec_q]  = mask_q[vec_q] | miss;
`ifdef CELL_TEST_CAPTURE_EN
    obs_d          = obs_q;
    obs_d[vec_q]   = y_smp;
`endif
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
`ifdef CELL_TEST_CAPTURE_EN
      obs_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            sel_q  <= cell_sel_i;
            vec_q  <= '0;
            cnt_q  <= '0;
            pass_q <= 1'b0;
            err_q  <= '0;
            mask_q <= '0;
`ifdef CELL_TEST_CAPTURE_EN
            obs_q  <= '0;
`endif
            // Out-of-map indices report immediately as a failed, unexercised cell.
            if (int'(cell_sel_i) < NCELLS) begin
              busy_q  <= 1'b1;
              state_q <= APPLY;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        APPLY: begin
          if (cnt_q == CNTW'(SETTLE - 1)) state_q <= SAMPLE;
          else                            cnt_q   <= cnt_q + 1'b1;
        end
        SAMPLE: begin
          err_q  <= err_d;
          mask_q <= mask_d;
`ifdef CELL_TEST_CAPTURE_EN
          obs_q  <= obs_d;
`endif
          if (last) begin
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 5'd0);
            state_q <= DONE;
          end else begin
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= '0;
            state_q <= APPLY;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cell_in_o   = vec_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_cnt_o   = err_q;
  assign fail_mask_o = mask_q;
`ifdef CELL_TEST_CAPTURE_EN
  assign obs_o       = obs_q;
`endif

endmodule

// File: tb/tb_cell_test_sequencer.sv
// Bench for cell_test_sequencer: a behavioural cell-array model with injectable faults feeds the DUT,
// and per-test expectations are derived from the cell truth tables with plain loops.
module tb_cell_test_sequencer;
  localparam int NCELLS = 19;
  localparam int SETTLE = 2;
  localparam int CNTW   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [4:0]        cell_sel_i = '0;
  logic [NCELLS-1:0] cell_y;
  logic [3:0]        cell_in_o;
  logic              busy_o, done_o, pass_o;
  logic [4:0]        err_cnt_o;
  logic [15:0]       fail_mask_o;
`ifdef CELL_TEST_CAPTURE_EN
  logic [15:0]       obs_o;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [4:0]  cur_sel   = '0;
  logic [15:0] flip      = '0;
  logic        stuck_en  = 1'b0;
  logic        stuck_val = 1'b0;
  logic [31:0] junk      = '0;

  cell_test_sequencer #(.NCELLS(NCELLS), .SETTLE(SETTLE), .CNTW(CNTW)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .start_i     (start_i),
    .cell_sel_i  (cell_sel_i),
    .cell_y_i    (cell_y),
    .cell_in_o   (cell_in_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .err_cnt_o   (err_cnt_o),
    .fail_mask_o (fail_mask_o)
`ifdef CELL_TEST_CAPTURE_EN
    ,
    .obs_o       (obs_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic int n_inputs(input int sel);
    case (sel)
      4, 5, 6, 7, 8, 9:         return 1;
      0, 1, 11, 13, 16, 17, 18: return 2;
      2, 10, 12, 14:            return 3;
      default:                  return 4;
    endcase
  endfunction

  // Healthy cell behaviour; v = {D,C,B,A}.
  function automatic logic ref_y(input int sel, input int v);
    logic a, b, c, d;
    a = v[0]; b = v[1]; c = v[2]; d = v[3];
    case (sel)
      0, 1:             return a & b;
      2:                return ~((a & b) | c);
      3:                return ~((a & b) | (c & d));
      4:                return a;
      5, 6, 7, 8, 9:    return ~a;
      10:               return c ? b : a;
      11:               return ~(a & b);
      12:               return ~(a & b & c);
      13:               return ~(a | b);
      14:               return ~((a | b) & c);
      15:               return ~((a | b) & (c | d));
      16, 17:           return a | b;
      default:          return a ^ b;
    endcase
  endfunction

  // Cell array: the selected cell answers (possibly faulted); all other outputs carry junk.
  always_comb begin
    cell_y = junk[NCELLS-1:0];
    if (int'(cur_sel) < NCELLS)
      cell_y[cur_sel] = stuck_en ? stuck_val
                                 : (ref_y(int'(cur_sel), int'(cell_in_o)) ^ flip[cell_in_o]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cell_in"}, 32'(cell_in_o), 32'd0);
    chk({tag, "_busy"},    32'(busy_o),    32'd0);
    chk({tag, "_done"},    32'(done_o),    32'd0);
    chk({tag, "_pass"},    32'(pass_o),    32'd0);
    chk({tag, "_err"},     32'(err_cnt_o), 32'd0);
    chk({tag, "_mask"},    32'(fail_mask_o), 32'd0);
`ifdef CELL_TEST_CAPTURE_EN
    chk({tag, "_obs"},     32'(obs_o),     32'd0);
`endif
  endtask

  task automatic run_test(input logic [4:0] sel, input logic [15:0] fl, input logic st_en,
                          input logic st_v, input bit restart, input bit done_poke);
    int n, lat, errs;
    logic [15:0] mask, obs;
    logic valid, pass, y;
    cur_sel = sel; flip = fl; stuck_en = st_en; stuck_val = st_v; junk = $urandom;
    valid = (int'(sel) < NCELLS);
    n = 1 << n_inputs(int'(sel));
    mask = '0; obs = '0; errs = 0;
    if (valid) begin
      for (int v = 0; v < n; v++) begin
        y = st_en ? st_v : (ref_y(int'(sel), v) ^ fl[v]);
        obs[v] = y;
        if (y !== ref_y(int'(sel), v)) begin
          mask[v] = 1'b1;
          errs++;
        end
      end
    end
    pass = valid && (errs == 0);
    lat  = valid ? n * (SETTLE + 1) + 1 : 1;

    cell_sel_i = sel;
    start_i    = 1'b1;
    step();
    start_i    = 1'b0;
    for (int k = 1; k < lat; k++) begin
      chk("busy_run",   32'(busy_o),    32'd1);
      chk("done_early", 32'(done_o),    32'd0);
      chk("cell_in",    32'(cell_in_o), 32'((k - 1) / (SETTLE + 1)));
      if (restart && k == 4) begin
        start_i    = 1'b1;
        cell_sel_i = sel ^ 5'd1;
      end else begin
        start_i = 1'b0;
      end
      step();
    end
    start_i = 1'b0;
    chk("done_pulse",   32'(done_o),      32'd1);
    chk("done_busy",    32'(busy_o),      32'd0);
    chk("done_cell_in", 32'(cell_in_o),   32'd0);
    chk("pass",         32'(pass_o),      32'(pass));
    chk("err_cnt",      32'(err_cnt_o),   32'(errs));
    chk("fail_mask",    32'(fail_mask_o), 32'(mask));
`ifdef CELL_TEST_CAPTURE_EN
    chk("obs",          32'(obs_o),       32'(obs));
`endif
    if (done_poke) begin
      start_i    = 1'b1;
      cell_sel_i = 5'd0;
    end
    step();
    start_i = 1'b0;
    chk("done_single", 32'(done_o),      32'd0);
    chk("idle_busy",   32'(busy_o),      32'd0);
    chk("hold_pass",   32'(pass_o),      32'(pass));
    chk("hold_err",    32'(err_cnt_o),   32'(errs));
    chk("hold_mask",   32'(fail_mask_o), 32'(mask));
`ifdef CELL_TEST_CAPTURE_EN
    chk("hold_obs",    32'(obs_o),       32'(obs));
`endif
    step();
    chk("idle_busy2", 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [4:0]  rsel;
    logic [15:0] rfl;

    rst = 1'b1;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    step();

    run_test(5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);  // AND2 healthy
    run_test(5'd18, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);  // XOR2 Y stuck at 0
    run_test(5'd3,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);  // AOI22 healthy, 16 vectors
    run_test(5'd25, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);  // out-of-map index

    // Reset during vector 5 of NAND3.
    cur_sel = 5'd12; flip = '0; stuck_en = 1'b0; junk = $urandom;
    cell_sel_i = 5'd12;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k < 17; k++) step();
    chk("rst_mid_vec", 32'(cell_in_o), 32'd5);
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    step();
    check_zero("rst_held");
    #2 rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      chk("rst_no_done", 32'(done_o), 32'd0);
    end
    run_test(5'd12, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    run_test(5'd10, 16'h0024, 1'b0, 1'b0, 1'b1, 1'b0);  // MUX2 with a second start while busy
    run_test(5'd5,  16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);  // INV fault, start poked during DONE
    run_test(5'd15, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);  // OAI22 boundary vectors 0 and 15
    run_test(5'd13, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);  // NOR2 stuck at 1

    for (int i = 0; i < 14; i++) begin
      rsel = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 18));
      rfl  = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      run_test(rsel, rfl, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
